// File: rtl/muldiv_pkg.sv
// Shared types and width-generic helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    // Operation codes match the RV32M funct3 field.
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } muldiv_state_t;

    // Helpers work on a wide carrier; the width argument selects the live bits.
    localparam int MAX_WIDTH = 128;
    typedef logic [MAX_WIDTH-1:0] wide_t;

    function automatic wide_t width_mask(input int unsigned width);
        if (width >= MAX_WIDTH) return '1;
        return (wide_t'(1) << width) - wide_t'(1);
    endfunction

    // Two's-complement negation confined to the low 'width' bits.
    function automatic wide_t negate(input wide_t value, input int unsigned width);
        return (~value + wide_t'(1)) & width_mask(width);
    endfunction

    // Magnitude of a 'width'-bit value; unsigned values pass through.
    function automatic wide_t abs_val(input wide_t value, input int unsigned width,
                                      input logic is_signed);
        wide_t sign_word;
        sign_word = value >> (width - 1);
        if (is_signed && sign_word[0]) return negate(value, width);
        return value & width_mask(width);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide sharing one double-width shift register and one adder/subtractor.
//
// Handshake: an operation is accepted on a clock edge where start=1, flush=0
// and the unit is not busy (IDLE or DONE). busy stays high while the result is
// being computed and any start seen then is dropped. done is a one-cycle strobe
// with result/rd_out valid in the same cycle. flush kills any in-flight work.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      flush,
    input  muldiv_op_t                op,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] rd_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef logic [W-1:0]   word_t;
    typedef logic [2*W-1:0] dword_t;

    muldiv_state_t state;
    logic [CW-1:0] count;
    muldiv_op_t    op_q;
    dword_t        sreg;      // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    word_t         mcand;     // multiplicand or divisor magnitude
    logic          neg_main;  // negate product / quotient
    logic          neg_rem;   // negate remainder

    logic   sign_a, sign_b, div_zero, div_ovf, special;
    word_t  mag_a, mag_b, special_res;
    word_t  add_a, add_b, fix_res, quot, rem;
    logic [W:0] sum;
    logic   ge;
    dword_t sreg_next, prod;

    // Accept-time decode: operand magnitudes, signs and the shortcut cases.
    always_comb begin
        sign_a   = op_a[W-1] & (op inside {MUL, MULH, MULHSU, DIV, REM});
        sign_b   = op_b[W-1] & (op inside {MULH, DIV, REM});
        mag_a    = word_t'(abs_val(wide_t'(op_a), W, sign_a));
        mag_b    = word_t'(abs_val(wide_t'(op_b), W, sign_b));
        div_zero = op[2] && (op_b == '0);
        div_ovf  = (op == DIV || op == REM) && (op_a == MOST_NEG) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = op[1] ? op_a : '1;
        else          special_res = op[1] ? '0   : op_a;
    end

    // One iteration step: add-then-shift for multiply, shift-then-trial-subtract for divide.
    always_comb begin
        add_a = op_q[2] ? sreg[2*W-2:W-1] : sreg[2*W-1:W];
        add_b = op_q[2] ? ~mcand : (sreg[0] ? mcand : '0);
        sum   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, op_q[2]};
        // Shifted remainder is {sreg top bit, add_a}; a carry out means it covers the divisor.
        ge    = sreg[2*W-1] | sum[W];
        if (!op_q[2])  sreg_next = {sum, sreg[W-1:1]};
        else if (ge)   sreg_next = {sum[W-1:0], sreg[W-2:0], 1'b1};
        else           sreg_next = {add_a, sreg[W-2:0], 1'b0};
    end

    // Sign fix-up and result selection once the iterations are complete.
    always_comb begin
        prod = neg_main ? dword_t'(negate(wide_t'(sreg), 2 * W)) : sreg;
        quot = neg_main ? word_t'(negate(wide_t'(sreg[W-1:0]), W)) : sreg[W-1:0];
        rem  = neg_rem  ? word_t'(negate(wide_t'(sreg[2*W-1:W]), W)) : sreg[2*W-1:W];
        case (op_q)
            MUL:                 fix_res = prod[W-1:0];
            MULH, MULHSU, MULHU: fix_res = prod[2*W-1:W];
            DIV, DIVU:           fix_res = quot;
            default:             fix_res = rem;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            op_q     <= MUL;
            sreg     <= '0;
            mcand    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            op_q   <= op;
                            rd_out <= rd_in;
                            if (special) begin
                                result <= special_res;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                sreg     <= op[2] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
                                mcand    <= op[2] ? mag_b : mag_a;
                                neg_main <= sign_a ^ sign_b;
                                neg_rem  <= sign_a;
                                count    <= '0;
                                busy     <= 1'b1;
                                state    <= S_CALC;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_CALC: begin
                        sreg  <= sreg_next;
                        count <= count + 1'b1;
                        if (count == LAST_STEP) begin
                            count <= '0;
                            state <= S_FIXUP;
                        end
                    end
                    S_FIXUP: begin
                        result <= fix_res;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops
// against an arithmetic reference model, and control-path sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int NORMAL_LAT = W + 2;

    logic clk = 1'b0;
    logic rst, start, flush;
    muldiv_op_t op;
    logic [W-1:0] op_a, op_b, result;
    logic [4:0] rd_in, rd_out;
    logic busy, done;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        muldiv_op_t   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   rd;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: RV32M semantics from plain integer arithmetic.
    function automatic logic [W-1:0] model(muldiv_op_t o, logic [W-1:0] a, logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint p;
        longint unsigned u;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            MUL:    begin p = sa * sb; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MULHU:  begin u = ua * ub; return u[63:32]; end
            DIV:    begin
                if (b == 0) return '1;
                if (ovf) return a;
                return 32'($signed(a) / $signed(b));
            end
            REM:    begin
                if (b == 0) return a;
                if (ovf) return '0;
                return 32'($signed(a) % $signed(b));
            end
            DIVU:   return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(muldiv_op_t o, logic [W-1:0] a, logic [W-1:0] b);
        if (o inside {DIV, DIVU, REM, REMU} && b == 0) return 1;
        if (o inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORMAL_LAT;
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd);
        op = o; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Cycle index s=1 is the first sample after the accepting edge.
    task automatic collect(input string name, output int s, output int busy_cnt,
                           output logic [W-1:0] res, output logic [4:0] rdo);
        s = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && s < 100) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            s++;
        end
        res = result;
        rdo = rd_out;
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input muldiv_op_t o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] rd,
                          input logic [W-1:0] exp, input int lat);
        int s, bc;
        logic [W-1:0] res;
        logic [4:0] rdo;
        issue(o, a, b, rd);
        collect(name, s, bc, res, rdo);
        check({name, "_result"}, 64'(res), 64'(exp));
        check({name, "_rd"}, 64'(rdo), 64'(rd));
        check({name, "_latency"}, 64'(s), 64'(lat));
        check({name, "_busy_cycles"}, 64'(bc), (lat == 1) ? 64'd0 : 64'(W + 1));
        step();
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) n++;
            step();
        end
    endtask

    initial begin
        int n, t, t1;
        logic [W-1:0] r;
        logic [4:0] rdv;
        muldiv_op_t ro;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = MUL; op_a = '0; op_b = '0; rd_in = '0;

        // Clock/reset block
        repeat (3) step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_rd_out", 64'(rd_out), 64'd0);
        rst = 1'b0;
        step();

        // Directed vectors
        vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, NORMAL_LAT};
        vecs[1]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, NORMAL_LAT};
        vecs[2]  = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, NORMAL_LAT};
        vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, NORMAL_LAT};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, NORMAL_LAT};
        vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, NORMAL_LAT};
        vecs[6]  = '{DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        NORMAL_LAT};
        vecs[7]  = '{REMU,   32'd100,        32'd7,         5'd8,  32'd2,         NORMAL_LAT};
        vecs[8]  = '{DIVU,   32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{REM,    32'd5,          32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = muldiv_op_t'(3'($urandom_range(0, 7)));
            ra = pick_val();
            rb = pick_val();
            run_op($sformatf("rand%0d_%s", i, ro.name()), ro, ra, rb, 5'($urandom_range(0, 31)),
                   model(ro, ra, rb), model_lat(ro, ra, rb));
        end

        // Flush on CALC cycle 10
        issue(MUL, 32'd123, 32'd456, 5'd13);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        count_dones(45, n);
        check("flush_no_done", 64'(n), 64'd0);

        // start while busy is dropped
        issue(DIVU, 32'd100, 32'd7, 5'd14);
        repeat (4) step();
        op = MUL; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd15; start = 1'b1;
        step();
        start = 1'b0;
        n = 0; r = '0; rdv = '0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin n++; r = result; rdv = rd_out; end
            step();
        end
        check("busy_start_done_count", 64'(n), 64'd1);
        check("busy_start_result", 64'(r), 64'd14);
        check("busy_start_rd", 64'(rdv), 64'd14);

        // start and flush together in IDLE
        op = DIVU; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd16;
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("start_flush_done", 64'(done), 64'd0);
        check("start_flush_busy", 64'(busy), 64'd0);
        count_dones(40, n);
        check("start_flush_no_done", 64'(n), 64'd0);

        // Back-to-back issue with start held through DONE
        op = MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd17; start = 1'b1;
        step();
        t = 1;
        while (done !== 1'b1 && t < 100) begin step(); t++; end
        t1 = t;
        check("b2b_first_latency", 64'(t1), 64'(NORMAL_LAT));
        check("b2b_first_result", 64'(result), 64'hFFFF_FFFE);
        op = DIVU; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd18;
        step();
        t++;
        start = 1'b0;
        while (done !== 1'b1 && t < 200) begin step(); t++; end
        check("b2b_spacing", 64'(t - t1), 64'(NORMAL_LAT));
        check("b2b_second_result", 64'(result), 64'd333);
        check("b2b_second_rd", 64'(rd_out), 64'd18);
        step();

        // Reset mid-CALC
        issue(REMU, 32'd999, 32'd10, 5'd19);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_rd_out", 64'(rd_out), 64'd0);
        count_dones(45, n);
        check("midrst_no_done", 64'(n), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
